// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data port responder with word RAM and programmable latency
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_data;
  logic                  lat_wr;
  logic [31:0]           din_q;
  logic [31:0]           ram [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] word;
  logic                  req, reject, accept, bad, commit;
  logic                  ram_we, rd_done, wr_done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata, ram_rdata;

  assign word   = mem_addr[ADDR_WIDTH+1:2];
  assign req    = mem_ren | mem_wen;
  assign reject = (mem_ren & mem_wen) | (mem_addr[1:0] != 2'b00) |
                  ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign accept = (state == IDLE) & req & ~reject;
  assign bad    = (state == IDLE) & req & reject;
  assign commit = (state == WAIT) & (cnt == 4'd0);

  // Zero latency serves straight from the bus; otherwise from the latched request.
  always_comb begin
    ram_addr  = lat_addr;
    ram_wdata = lat_data;
    rd_done   = commit & ~lat_wr;
    wr_done   = commit & lat_wr;
    if (LATENCY == 0) begin
      ram_addr  = word;
      ram_wdata = mem_dout;
      rd_done   = accept & mem_ren;
      wr_done   = accept & mem_wen;
    end
  end

  assign ram_we    = rst_n & wr_done;
  assign ram_rdata = ram[ram_addr];
  assign mem_din   = (LATENCY == 0 && rd_done) ? ram_rdata : din_q;
  assign mem_stall = rst_n & (((LATENCY != 0) & accept) | (state == WAIT));

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_data <= 32'd0;
      lat_wr   <= 1'b0;
      din_q    <= 32'd0;
      mem_err  <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      mem_err <= bad;
      if (rd_done) begin
        din_q <= ram_rdata;
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
      if (wr_done && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      case (state)
        IDLE: begin
          if (accept && LATENCY != 0) begin
            state    <= WAIT;
            cnt      <= CNT_INIT;
            lat_addr <= word;
            lat_data <= mem_dout;
            lat_wr   <= mem_wen;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren, wen;
  logic [31:0] addr, dout;
  logic [31:0] din2, din0;
  logic        stall2, stall0, err2, err0;
  logic [15:0] rdc2, wrc2, rdc0, wrc0;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_dout(dout), .mem_din(din2), .mem_stall(stall2), .mem_err(err2),
    .rd_count(rdc2), .wr_count(wrc2)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_dout(dout), .mem_din(din0), .mem_stall(stall0), .mem_err(err0),
    .rd_count(rdc0), .wr_count(wrc0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; dout = d;
  endtask

  // Full access on the LATENCY=2 instance; checks stall length and RESP-cycle data.
  task automatic acc2(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic chk_din, input logic [31:0] exp_din);
    int stalls = 0;
    drive(r, w, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall2) stalls++;
      else break;
    end
    check({tag, "_stall"}, stalls, 3);
    if (chk_din) check({tag, "_din"}, din2, exp_din);
    @(posedge clk); #1;
    drive(0, 0, 32'd0, 32'd0);
  endtask

  task automatic rej(input string tag, input logic r, input logic w, input logic [31:0] a);
    drive(r, w, a, 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_stall"}, stall2, 1'b0);
    @(posedge clk); #1;
    drive(0, 0, 32'd0, 32'd0);
    @(negedge clk);
    check({tag, "_err"}, err2, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_end"}, err2, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 32'h10, 32'd0);
    #12;
    check("rst_stall", stall2, 1'b0);
    check("rst_din", din2, 32'd0);
    check("rst_err", err2, 1'b0);
    check("rst_counts", {rdc2, wrc2}, 32'd0);
    drive(0, 0, 32'd0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write then read back at LATENCY 2
    acc2("t1_wr", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'd0);
    check("t1_wrc", wrc2, 16'd1);
    acc2("t1_rd", 1, 0, 32'h10, 32'd0, 1, 32'hDEADBEEF);
    check("t1_rdc", rdc2, 16'd1);

    // 2: misaligned read
    rej("t2", 1, 0, 32'h13);
    check("t2_din", din2, 32'hDEADBEEF);
    check("t2_counts", {rdc2, wrc2}, {16'd1, 16'd1});

    // 3: conflicting op and out-of-range address
    acc2("t3_pre", 0, 1, 32'h20, 32'h12345678, 0, 32'd0);
    rej("t3_both", 1, 1, 32'h20);
    rej("t3_range", 1, 0, 32'h0000_1000);
    check("t3_counts", {rdc2, wrc2}, {16'd1, 16'd2});
    acc2("t3_rd", 1, 0, 32'h20, 32'd0, 1, 32'h12345678);

    // 4: bus changes during WAIT are ignored
    acc2("t4_pre", 0, 1, 32'h44, 32'hCAFE0044, 0, 32'd0);
    drive(0, 1, 32'h40, 32'h1);
    @(posedge clk); #1;
    drive(0, 1, 32'h44, 32'h2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall2) break;
    end
    @(posedge clk); #1;
    drive(0, 0, 32'd0, 32'd0);
    acc2("t4_rd40", 1, 0, 32'h40, 32'd0, 1, 32'h1);
    acc2("t4_rd44", 1, 0, 32'h44, 32'd0, 1, 32'hCAFE0044);

    // 5: reset during WAIT aborts the write
    acc2("t5_pre", 0, 1, 32'h08, 32'h0BAD0008, 0, 32'd0);
    drive(0, 1, 32'h08, 32'h55);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_stall", stall2, 1'b0);
    check("t5_counts", {rdc2, wrc2}, 32'd0);
    check("t5_din", din2, 32'd0);
    drive(0, 0, 32'd0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    acc2("t5_rd", 1, 0, 32'h08, 32'd0, 1, 32'h0BAD0008);

    // 6: LATENCY 0 back-to-back and counter saturation
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1, 32'h0C, 32'hA5A5A5A5);
    @(negedge clk);
    check("t6_wr_stall", stall0, 1'b0);
    @(posedge clk); #1;
    drive(1, 0, 32'h0C, 32'd0);
    @(negedge clk);
    check("t6_rd_stall", stall0, 1'b0);
    check("t6_rd_din", din0, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("t6_counts", {rdc0, wrc0}, {16'd1, 16'd1});
    drive(0, 1, 32'h100, 32'h77);
    repeat (65533) @(posedge clk);
    #1;
    check("t6_wrc_fffe", wrc0, 16'hFFFE);
    @(posedge clk); #1;
    check("t6_wrc_ffff", wrc0, 16'hFFFF);
    @(posedge clk); #1;
    check("t6_wrc_sat", wrc0, 16'hFFFF);
    drive(0, 0, 32'd0, 32'd0);
    @(negedge clk);
    check("t6_din_hold", din0, 32'hA5A5A5A5);
    check("t6_rdc", rdc0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
